// File: rtl/uart_8250_pkg.sv
// Shared constants for the 8250-compatible UART: register indices, IIR codes,
// LSR bit positions and loopback frame timing.
package uart_8250_pkg;

    localparam logic [2:0] RBR_THR = 3'd0;
    localparam logic [2:0] IER_DLM = 3'd1;
    localparam logic [2:0] IIR_FCR = 3'd2;
    localparam logic [2:0] LCR     = 3'd3;
    localparam logic [2:0] MCR     = 3'd4;
    localparam logic [2:0] LSR     = 3'd5;
    localparam logic [2:0] MSR     = 3'd6;
    localparam logic [2:0] SCR     = 3'd7;

    localparam logic [7:0] IIR_RLS  = 8'h06;
    localparam logic [7:0] IIR_RDA  = 8'h04;
    localparam logic [7:0] IIR_THRE = 8'h02;
    localparam logic [7:0] IIR_NONE = 8'h01;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    // 10 bits x 16 oversample ticks per frame
    localparam logic [7:0] FRAME_LEN = 8'd160;

    function automatic logic [15:0] eff_divisor(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_8250_baud_tx.sv
// Loopback frame timer: D clocks per oversample tick, FRAME_LEN ticks per frame.
// A start pulse launches a frame; done pulses on the last clock of it.
module uart_8250_baud_tx
    import uart_8250_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        start,
    output logic        busy,
    output logic        done
);

    logic [15:0] div_cnt_r;
    logic [7:0]  tick_cnt_r;
    logic        busy_r;
    logic [15:0] div_eff_s;
    logic        tick_s;

    assign div_eff_s = eff_divisor(divisor);
    // >= keeps the counter sane if the divisor shrinks mid-frame
    assign tick_s    = busy_r && (div_cnt_r >= (div_eff_s - 16'd1));
    assign done      = tick_s && (tick_cnt_r == (FRAME_LEN - 8'd1));
    assign busy      = busy_r;

    // Divisor and tick counters advance only while a frame is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            div_cnt_r  <= 16'd0;
            tick_cnt_r <= 8'd0;
        end else if (start) begin
            busy_r     <= 1'b1;
            div_cnt_r  <= 16'd0;
            tick_cnt_r <= 8'd0;
        end else if (busy_r) begin
            if (tick_s) begin
                div_cnt_r  <= 16'd0;
                tick_cnt_r <= tick_cnt_r + 8'd1;
                if (done) begin
                    busy_r <= 1'b0;
                end
            end else begin
                div_cnt_r <= div_cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: rtl/uart_8250.sv
// 8250/16450-style UART register block on a 32-bit Wishbone classic slave.
// Transmitted bytes loop back to the receiver after one divisor-timed frame.
module uart_8250
    import uart_8250_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1250_0000
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic        WE_I,
    input  logic [3:0]  SEL_I,
    input  logic        STB_I,
    output logic        ACK_O,
    input  logic        CYC_I,
    output logic        INT_O
);

    logic        ack_r, int_r, thr_full_r, go_r, dr_r, oe_r, thre_r, temt_r, thre_pend_r;
    logic [31:0] dat_r;
    logic [3:0]  ier_r;
    logic [4:0]  mcr_r;
    logic [7:0]  lcr_r, scr_r, dll_r, dlm_r, rbr_r, thr_r, shift_r;
    logic [2:0]  idx_s;
    logic [7:0]  rdata_s, lsr_s, iir_s;
    logic        access_s, wr_s, rd_s, dlab_s, busy_s, done_s;
    logic        thr_wr_s, rbr_rd_s, lsr_rd_s, iir_rd_s, ier_wr_s;
    logic        unused_s;

    assign idx_s    = ADR_I[4:2];
    assign access_s = (ADR_I[31:5] == BASE_ADDR[31:5]) && CYC_I && STB_I && !ack_r;
    assign wr_s     = access_s && WE_I && SEL_I[0];
    assign rd_s     = access_s && !WE_I;
    assign dlab_s   = lcr_r[7];
    assign thr_wr_s = wr_s && (idx_s == RBR_THR) && !dlab_s;
    assign ier_wr_s = wr_s && (idx_s == IER_DLM) && !dlab_s;
    assign rbr_rd_s = rd_s && (idx_s == RBR_THR) && !dlab_s;
    assign iir_rd_s = rd_s && (idx_s == IIR_FCR);
    assign lsr_rd_s = rd_s && (idx_s == LSR);
    assign lsr_s    = {1'b0, temt_r, thre_r, 3'b000, oe_r, dr_r};
    assign unused_s = ^{ADR_I[1:0], DAT_I[31:8], SEL_I[3:1]};

    assign DAT_O = dat_r;
    assign ACK_O = ack_r;
    assign INT_O = int_r;

    uart_8250_baud_tx u_baud (
        .clk     (CLK_I),
        .rst     (RST_I),
        .divisor ({dlm_r, dll_r}),
        .start   (go_r),
        .busy    (busy_s),
        .done    (done_s)
    );

    // Interrupt identification by fixed priority
    always_comb begin
        iir_s = IIR_NONE;
        if (oe_r && ier_r[2]) begin
            iir_s = IIR_RLS;
        end else if (dr_r && ier_r[0]) begin
            iir_s = IIR_RDA;
        end else if (thre_pend_r && ier_r[1]) begin
            iir_s = IIR_THRE;
        end else begin
            iir_s = IIR_NONE;
        end
    end

    // Read data mux
    always_comb begin
        rdata_s = 8'h00;
        case (idx_s)
            RBR_THR: rdata_s = dlab_s ? dll_r : rbr_r;
            IER_DLM: rdata_s = dlab_s ? dlm_r : {4'h0, ier_r};
            IIR_FCR: rdata_s = iir_s;
            LCR:     rdata_s = lcr_r;
            MCR:     rdata_s = {3'b000, mcr_r};
            LSR:     rdata_s = lsr_s;
            SCR:     rdata_s = scr_r;
            default: rdata_s = 8'h00;
        endcase
    end

    // Bus handshake, registered read data and interrupt line
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
            int_r <= 1'b0;
        end else begin
            ack_r <= access_s;
            int_r <= (iir_s != IIR_NONE);
            if (rd_s) begin
                dat_r <= {24'h00_0000, rdata_s};
            end
        end
    end

    // Configuration registers written from the bus
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ier_r <= 4'h0;
            lcr_r <= 8'h00;
            mcr_r <= 5'h00;
            scr_r <= 8'h00;
            dll_r <= 8'h01;
            dlm_r <= 8'h00;
        end else if (wr_s) begin
            case (idx_s)
                RBR_THR: if (dlab_s) dll_r <= DAT_I[7:0];
                IER_DLM: if (dlab_s) dlm_r <= DAT_I[7:0]; else ier_r <= DAT_I[3:0];
                LCR:     lcr_r <= DAT_I[7:0];
                MCR:     mcr_r <= DAT_I[4:0];
                SCR:     scr_r <= DAT_I[7:0];
                default: ;
            endcase
        end
    end

    // Transmit holding/shifter, receive buffer and line status
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            thr_r       <= 8'h00;
            shift_r     <= 8'h00;
            rbr_r       <= 8'h00;
            thr_full_r  <= 1'b0;
            go_r        <= 1'b0;
            dr_r        <= 1'b0;
            oe_r        <= 1'b0;
            thre_r      <= 1'b1;
            temt_r      <= 1'b1;
            thre_pend_r <= 1'b0;
        end else begin
            // THR moves to the shifter one cycle after it is seen full with the shifter idle
            go_r <= thr_full_r && !busy_s && !go_r;
            if (go_r) begin
                shift_r <= thr_r;
            end
            if (thr_wr_s) begin
                thr_r      <= DAT_I[7:0];
                thr_full_r <= 1'b1;
                thre_r     <= 1'b0;
                temt_r     <= 1'b0;
            end else if (go_r) begin
                thr_full_r <= 1'b0;
                thre_r     <= 1'b1;
                temt_r     <= 1'b0;
            end else if (done_s && !thr_full_r) begin
                temt_r <= 1'b1;
            end
            if (done_s) begin
                rbr_r <= shift_r;
                dr_r  <= 1'b1;
            end else if (rbr_rd_s) begin
                dr_r <= 1'b0;
            end
            oe_r <= (oe_r && !lsr_rd_s) || (done_s && dr_r && !rbr_rd_s);
            if (thr_wr_s) begin
                thre_pend_r <= 1'b0;
            end else if ((go_r && !thre_r) || (ier_wr_s && DAT_I[1] && !ier_r[1] && thre_r)) begin
                thre_pend_r <= 1'b1;
            end else if (iir_rd_s && (iir_s == IIR_THRE)) begin
                thre_pend_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_8250.sv
// Scoreboard bench for uart_8250: bus tasks queue expected read data,
// a monitor compares DAT_O on every ACK.
module tb_uart_8250;

    localparam logic [31:0] BASE = 32'h1250_0000;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic [31:0] ADR_I = 32'h0;
    logic [31:0] DAT_I = 32'h0;
    logic [31:0] DAT_O;
    logic        WE_I  = 1'b0;
    logic [3:0]  SEL_I = 4'h0;
    logic        STB_I = 1'b0;
    logic        ACK_O;
    logic        CYC_I = 1'b0;
    logic        INT_O;

    typedef struct {
        bit          check;
        logic [7:0]  exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    uart_8250 #(.BASE_ADDR(BASE)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
        .WE_I(WE_I), .SEL_I(SEL_I), .STB_I(STB_I), .ACK_O(ACK_O), .CYC_I(CYC_I),
        .INT_O(INT_O)
    );

    always #5 CLK_I = ~CLK_I;

    // Monitor: every ACK consumes one queued expectation
    always @(negedge CLK_I) begin
        exp_t e;
        if (!RST_I && ACK_O) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: DAT_O=%h with no access pending", DAT_O);
            end else begin
                e = sb_q.pop_front();
                if (e.check) begin
                    vectors++;
                    if (DAT_O !== {24'h0, e.exp}) begin
                        miscompares++;
                        $display("FAIL %s: DAT_O=%h expected %h", e.name, DAT_O, {24'h0, e.exp});
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    task automatic bus(input logic [31:0] addr, input bit we, input logic [3:0] sel,
                       input logic [7:0] data, input logic [7:0] exp, input string name);
        exp_t e;
        int   n;
        e.check = !we;
        e.exp   = exp;
        e.name  = name;
        sb_q.push_back(e);
        ADR_I = addr; WE_I = we; SEL_I = sel; DAT_I = {24'h0, data};
        CYC_I = 1'b1; STB_I = 1'b1;
        n = 0;
        do begin
            @(posedge CLK_I); #1;
            n++;
        end while (!ACK_O && n < 8);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        if (!ACK_O) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no ACK within 8 cycles", name);
            e = sb_q.pop_back();
        end
    endtask

    task automatic rd(input logic [2:0] idx, input logic [7:0] exp, input string name);
        bus(BASE + {27'h0, idx, 2'b00}, 1'b0, 4'hF, 8'h00, exp, name);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [7:0] data);
        bus(BASE + {27'h0, idx, 2'b00}, 1'b1, 4'h1, data, 8'h00, "write");
    endtask

    task automatic miss(input logic [31:0] addr, input bit we);
        int acks = 0;
        ADR_I = addr; WE_I = we; SEL_I = 4'hF; DAT_I = 32'hFF;
        CYC_I = 1'b1; STB_I = 1'b1;
        repeat (4) begin
            @(posedge CLK_I); #1;
            if (ACK_O) acks++;
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        check($sformatf("miss_%h", addr), acks, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        wait_clk(3);
        check("rst_ack", {31'h0, ACK_O}, 32'h0);
        check("rst_dat", DAT_O, 32'h0);
        check("rst_int", {31'h0, INT_O}, 32'h0);
        @(negedge CLK_I); RST_I = 1'b0;
        wait_clk(1);

        // Address decode: hits with ignored low bits, then misses
        bus(BASE + 32'h0,  1'b0, 4'hF, 8'h00, 8'h00, "hit_0");
        bus(BASE + 32'h1,  1'b0, 4'hF, 8'h00, 8'h00, "hit_1");
        bus(BASE + 32'h2,  1'b0, 4'hF, 8'h00, 8'h00, "hit_2");
        bus(BASE + 32'h3,  1'b0, 4'hF, 8'h00, 8'h00, "hit_3");
        bus(BASE + 32'h10, 1'b0, 4'hF, 8'h00, 8'h00, "hit_mcr");
        miss(32'h1250_00A0, 1'b0);
        miss(32'h1256_0002, 1'b0);
        miss(32'h0250_0000, 1'b0);
        miss(32'hF250_0005, 1'b0);
        miss(32'hF250_001C, 1'b1);
        rd(3'd7, 8'h00, "scr_after_miss_wr");
        rd(3'd5, 8'h60, "lsr_reset");
        rd(3'd2, 8'h01, "iir_reset");

        // Byte select
        bus(BASE + 32'h1C, 1'b1, 4'b0010, 8'h77, 8'h00, "scr_wr_sel1");
        rd(3'd7, 8'h00, "scr_sel1_ignored");
        bus(BASE + 32'h1C, 1'b1, 4'b0001, 8'hA5, 8'h00, "scr_wr_sel0");
        rd(3'd7, 8'hA5, "scr_sel0");

        // Loopback at D=1
        wr(3'd3, 8'h80); wr(3'd0, 8'h01); wr(3'd1, 8'h00); wr(3'd3, 8'h00);
        wr(3'd0, 8'h5A);
        rd(3'd5, 8'h00, "lsr_thr_full");
        rd(3'd5, 8'h20, "lsr_shifting");
        wait_clk(150);
        rd(3'd5, 8'h20, "lsr_before_frame_end");
        wait_clk(10);
        rd(3'd5, 8'h61, "lsr_frame_done");
        rd(3'd0, 8'h5A, "rbr_5a");
        rd(3'd5, 8'h60, "lsr_after_rbr");

        // Divisor 0 behaves as 1
        wr(3'd3, 8'h80); wr(3'd0, 8'h00);
        rd(3'd0, 8'h00, "dll_zero");
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h81);
        wait_clk(170);
        rd(3'd5, 8'h61, "lsr_div0_done");
        rd(3'd0, 8'h81, "rbr_div0");
        wr(3'd3, 8'h80); wr(3'd0, 8'h01); wr(3'd3, 8'h00);

        // Overrun
        wr(3'd0, 8'h11);
        wr(3'd0, 8'h22);
        wait_clk(400);
        wr(3'd1, 8'h04);
        rd(3'd2, 8'h06, "iir_rls");
        check("int_rls", {31'h0, INT_O}, 32'h1);
        rd(3'd5, 8'h63, "lsr_overrun");
        rd(3'd2, 8'h01, "iir_after_lsr_rd");
        rd(3'd0, 8'h22, "rbr_second_byte");
        rd(3'd5, 8'h60, "lsr_after_overrun");
        wr(3'd1, 8'h00);

        // Interrupt priority
        wr(3'd1, 8'h03);
        wait_clk(1);
        check("int_thre", {31'h0, INT_O}, 32'h1);
        rd(3'd2, 8'h02, "iir_thre");
        rd(3'd2, 8'h01, "iir_thre_cleared");
        check("int_cleared", {31'h0, INT_O}, 32'h0);
        wr(3'd0, 8'h3C);
        wait_clk(170);
        rd(3'd2, 8'h04, "iir_rda");
        rd(3'd2, 8'h04, "iir_rda_held");
        rd(3'd0, 8'h3C, "rbr_3c");
        rd(3'd2, 8'h02, "iir_thre_again");
        rd(3'd2, 8'h01, "iir_none");
        wr(3'd1, 8'h00);

        // Reset in the middle of a frame and a bus cycle
        wr(3'd1, 8'h02);
        wr(3'd0, 8'h99);
        wait_clk(3);
        check("int_before_reset", {31'h0, INT_O}, 32'h1);
        ADR_I = BASE + 32'h14; WE_I = 1'b0; SEL_I = 4'hF; CYC_I = 1'b1; STB_I = 1'b1;
        @(posedge CLK_I); #2;
        RST_I = 1'b1;
        #1;
        check("async_rst_ack", {31'h0, ACK_O}, 32'h0);
        check("async_rst_int", {31'h0, INT_O}, 32'h0);
        CYC_I = 1'b0; STB_I = 1'b0;
        @(negedge CLK_I); RST_I = 1'b0;
        wait_clk(1);
        rd(3'd5, 8'h60, "lsr_after_rst");
        rd(3'd2, 8'h01, "iir_after_rst");
        rd(3'd3, 8'h00, "lcr_after_rst");
        wr(3'd3, 8'h80);
        rd(3'd0, 8'h01, "dll_after_rst");
        rd(3'd1, 8'h00, "dlm_after_rst");
        wr(3'd3, 8'h00);
        wait_clk(200);
        rd(3'd5, 8'h60, "lsr_frame_aborted");
        rd(3'd0, 8'h00, "rbr_after_rst");

        wait_clk(4);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
